// File: rtl/generic_fifo_stream_drain_if.sv
// Read-port and output-stream signals of the FIFO drain stage.
// The master side is the drain; the slave side is the FIFO plus the downstream consumer.
interface generic_fifo_stream_drain_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  fifo_empty;
  logic                  fifo_read;
  logic [DATA_WIDTH-1:0] fifo_read_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    input  fifo_empty, fifo_read_data, out_ready,
    output fifo_read, out_valid, out_data
  );

  modport slave (
    output fifo_empty, fifo_read_data, out_ready,
    input  fifo_read, out_valid, out_data
  );
endinterface

// File: rtl/generic_fifo_stream_drain.sv
// Drains generic_fifo into a registered valid/ready stream.
// A 2-entry buffer hides the FIFO's one-cycle read latency and sustains 1 word/clk.
module generic_fifo_stream_drain #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_poweron_n,
  input  logic                       clear,
  generic_fifo_stream_drain_if.master bus,
  output logic [COUNT_WIDTH-1:0]     xfer_count,
  output logic                       busy
);

  logic [DATA_WIDTH-1:0]  data_q [2];
  logic [DATA_WIDTH-1:0]  data_d [2];
  logic [1:0]             buf_cnt_q, buf_cnt_d;
  logic                   inflight_q, inflight_d;
  logic                   drop_q, drop_d;
  logic [COUNT_WIDTH-1:0] xfer_count_q, xfer_count_d;

  logic       pop;
  logic       cap;
  logic       overflow;
  logic [2:0] occ;

  always_comb begin
    pop           = (buf_cnt_q != 2'd0) & bus.out_ready;
    occ           = {1'b0, buf_cnt_q} + {2'b00, inflight_q};
    // Reads are issued only while buffered plus in-flight words, net of this pop, stay below 2.
    bus.fifo_read = reset_poweron_n & ~clear & ~bus.fifo_empty
                    & ((occ - {2'b00, pop}) < 3'd2);
    cap           = inflight_q & ~drop_q;

    data_d       = data_q;
    buf_cnt_d    = buf_cnt_q;
    overflow     = 1'b0;
    inflight_d   = bus.fifo_read;
    drop_d       = clear & inflight_q;
    xfer_count_d = xfer_count_q + COUNT_WIDTH'(pop);

    if (pop) begin
      data_d[0] = data_q[1];
      buf_cnt_d = buf_cnt_q - 2'd1;
    end
    // Capture lands at the tail left after any same-edge pop, keeping strict FIFO order.
    if (cap) begin
      if (buf_cnt_d == 2'd0) begin
        data_d[0] = bus.fifo_read_data;
      end else begin
        data_d[1] = bus.fifo_read_data;
      end
      overflow  = (buf_cnt_d == 2'd2);
      buf_cnt_d = buf_cnt_d + 2'd1;
    end

    if (clear) begin
      buf_cnt_d    = '0;
      xfer_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_poweron_n) begin
      data_q[0]    <= '0;
      data_q[1]    <= '0;
      buf_cnt_q    <= '0;
      inflight_q   <= 1'b0;
      drop_q       <= 1'b0;
      xfer_count_q <= '0;
    end else begin
      data_q       <= data_d;
      buf_cnt_q    <= buf_cnt_d;
      inflight_q   <= inflight_d;
      drop_q       <= drop_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign bus.out_valid = (buf_cnt_q != 2'd0);
  assign bus.out_data  = data_q[0];
  assign xfer_count    = xfer_count_q;
  assign busy          = (buf_cnt_q != 2'd0) | inflight_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_poweron_n)
    !overflow && (buf_cnt_q <= 2'd2));

endmodule
